// File: rtl/avalon_mem_master_pkg.sv
// Shared types for the CPU-side Avalon-MM master: access sizes and FSM states.
package avalon_mem_master_pkg;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/avalon_mem_master_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module mem_lane_align
  import avalon_mem_master_pkg::*;
(
  input  mem_size_t   wr_size,
  input  logic [1:0]  wr_lane,
  input  logic [31:0] wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  mem_size_t   rd_size,
  input  logic        rd_signed,
  input  logic [1:0]  rd_lane,
  input  logic [31:0] readdata,
  output logic [31:0] rdata
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    byteenable = 4'b1111;
    writedata  = wdata;
    case (wr_size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << wr_lane;
        writedata  = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        byteenable = wr_lane[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = readdata[8*rd_lane +: 8];
    rd_half = readdata[16*rd_lane[1] +: 16];
    rdata   = readdata;
    case (rd_size)
      SIZE_BYTE: rdata = {{24{rd_signed & rd_byte[7]}}, rd_byte};
      SIZE_HALF: rdata = {{16{rd_signed & rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/avalon_mem_master.sv
// CPU load/store to single-beat Avalon-MM master. Define AVALON_MEM_MASTER_ALIGN_CHECK_EN
// to reject misaligned half/word requests with resp_error instead of force-aligning them.
module avalon_mem_master
  import avalon_mem_master_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
  ,
  output logic        resp_error
`endif
);

  state_t      state_q, state_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  mem_size_t   size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        misaligned;

  mem_lane_align u_align (
    .wr_size    (mem_size_t'(req_size)),
    .wr_lane    (req_addr[1:0]),
    .wdata      (req_wdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .rd_size    (size_q),
    .rd_signed  (signed_q),
    .rd_lane    (lane_q),
    .readdata   (readdata),
    .rdata      (lane_rdata)
  );

`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
  logic resp_error_q, resp_error_d;

  always_comb begin
    misaligned = 1'b0;
    if (mem_size_t'(req_size) == SIZE_HALF) misaligned = req_addr[0];
    else if (mem_size_t'(req_size) != SIZE_BYTE) misaligned = |req_addr[1:0];
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
    resp_error_d = resp_error_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d   = mem_size_t'(req_size);
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
          resp_error_d = misaligned;
`endif
          if (misaligned) begin
            // Rejected without touching the bus.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d   = CMD;
            address_d = {req_addr[31:2], 2'b00};
            read_d    = ~req_write;
            write_d   = req_write;
            be_d      = lane_be;
            wdata_d   = lane_wdata;
          end
        end
      end
      CMD: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = RDATA;
          end
        end
      end
      RDATA: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = lane_rdata;
      end
      RESP: begin
        state_d   = IDLE;
        address_d = RESET_ADDR;
        be_d      = '0;
        wdata_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      address_q    <= RESET_ADDR;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      size_q       <= SIZE_WORD;
      signed_q     <= 1'b0;
      lane_q       <= '0;
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
      resp_error_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
      resp_error_q <= resp_error_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
  assign resp_error = resp_error_q;
`endif

endmodule

// File: tb/tb_avalon_mem_master.sv
// Directed plus randomized load/store checks of avalon_mem_master against an arithmetic reference.
module tb_avalon_mem_master;
  import avalon_mem_master_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;
  logic        waitrequest = 1'b0;
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
  logic        resp_error;
`endif

  int n_cmp = 0;
  int n_err = 0;

  avalon_mem_master #(.RESET_ADDR(RST_ADDR)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest)
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
    ,
    .resp_error  (resp_error)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction: the bench plays the slave, checks the bus each cycle and the response.
  task automatic txn(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rw, input int nwait);
    logic [31:0] exp_addr, exp_wd, exp_rd, sh;
    logic [3:0]  exp_be;
    bit          exp_err;
    int          lane, exp_lat, lat;
    lane    = int'(a[1:0]);
    exp_err = 1'b0;
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
    exp_err = (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`endif
    exp_addr = a - (a % 4);
    case (sz)
      2'd0: begin
        exp_be = 4'(1 << lane);
        exp_wd = (wd % 256) * 32'h01010101;
        sh     = (rw >> (8 * lane)) % 256;
        exp_rd = (sg && sh >= 128) ? sh - 256 : sh;
      end
      2'd1: begin
        exp_be = (lane >= 2) ? 4'hC : 4'h3;
        exp_wd = (wd % 65536) * 32'h00010001;
        sh     = (rw >> ((lane >= 2) ? 16 : 0)) % 65536;
        exp_rd = (sg && sh >= 32768) ? sh - 65536 : sh;
      end
      default: begin
        exp_be = 4'hF;
        exp_wd = wd;
        exp_rd = rw;
      end
    endcase
    if (wr || exp_err) exp_rd = 32'h0;
    exp_lat = exp_err ? 1 : (wr ? 2 + nwait : 3 + nwait);

    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      waitrequest = (c <= nwait);
      readdata    = (c == nwait + 2) ? rw : $urandom;
      if (!exp_err && c <= nwait + 1) begin
        check("cmd_read",  {31'b0, read},  {31'b0, ~wr});
        check("cmd_write", {31'b0, write}, {31'b0, wr});
        check("cmd_addr",  address, exp_addr);
        check("cmd_be",    {28'b0, byteenable}, {28'b0, exp_be});
        if (wr) check("cmd_wdata", writedata, exp_wd);
      end else begin
        check("bus_quiet", {30'b0, read, write}, 32'd0);
      end
      if (resp_valid) begin
        lat = c;
      end else begin
        // Requests offered while busy must be ignored.
        req_valid = 1'($urandom);
        req_write = 1'($urandom); req_size = 2'($urandom_range(0, 2));
        req_addr = $urandom; req_wdata = $urandom; req_signed = 1'($urandom);
      end
    end
    req_valid = 1'b0;
    waitrequest = 1'b0;
    check("resp_latency", lat, exp_lat);
    check("resp_rdata", resp_rdata, exp_rd);
`ifdef AVALON_MEM_MASTER_ALIGN_CHECK_EN
    check("resp_error", {31'b0, resp_error}, {31'b0, exp_err});
`endif
    $display("txn wr=%0d size=%0d signed=%0d addr=%h wait=%0d latency=%0d rdata=%h", wr, sz, sg, a,
             nwait, lat, resp_rdata);
    @(negedge clk);
    check("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    check("ready_after",    {31'b0, req_ready}, 32'd1);
    check("rdata_held",     resp_rdata, exp_rd);
    check("addr_idle",      address, RST_ADDR);
    if (lat == 0) begin
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
    end
  endtask

  initial begin
    #12;
    check("rst_read",  {31'b0, read},  32'd0);
    check("rst_write", {31'b0, write}, 32'd0);
    check("rst_addr",  address, RST_ADDR);
    check("rst_be",    {28'b0, byteenable}, 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_resp",  {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    txn(1'b1, 2'd2, 1'b0, 32'hBFC00010, 32'hDEADBEEF, 32'h0, 0);
    txn(1'b1, 2'd0, 1'b0, 32'hBFC00013, 32'h000000A5, 32'h0, 0);
    txn(1'b0, 2'd0, 1'b1, 32'hBFC00013, 32'h0, 32'h80112233, 0);
    txn(1'b0, 2'd0, 1'b0, 32'hBFC00013, 32'h0, 32'h80112233, 0);
    txn(1'b0, 2'd1, 1'b1, 32'hBFC00012, 32'h0, 32'h80112233, 3);
    txn(1'b1, 2'd1, 1'b0, 32'hBFC00006, 32'h1234ABCD, 32'h0, 2);
    txn(1'b0, 2'd2, 1'b0, 32'hBFC00002, 32'h0, 32'h5A5AC3C3, 0);
    txn(1'b0, 2'd1, 1'b1, 32'hBFC00001, 32'h0, 32'h0000F00F, 1);

    // Abort mid-command: read must fall with reset, no response afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'hBFC00020;
    @(posedge clk);
    #1 req_valid = 1'b0; waitrequest = 1'b1;
    @(negedge clk);
    check("abort_read_before", {31'b0, read}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_read_now", {31'b0, read}, 32'd0);
    check("abort_resp",     {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      check("abort_ready",   {31'b0, req_ready}, 32'd1);
      check("abort_addr",    address, RST_ADDR);
    end

    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
          RST_ADDR + 32'($urandom_range(0, 1023)), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_mem_master.md
Name: avalon_mem_master

Overview:
- CPU-side Avalon-MM master; it is the initiator counterpart to the word-addressed Avalon RAM/memory slaves.
- Takes one load/store request (byte, half or word) from the CPU datapath and issues a single word-aligned Avalon read or write.
- Honours waitrequest, captures readdata one cycle after the read is accepted, and returns a sign/zero-extended result.
- Sits between the CPU core (instruction fetch or data port) and the memory bus.

Parameters:
- RESET_ADDR, 32'hBFC00000, value driven on `address` while idle and at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  high in IDLE only; a request is accepted on the edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  mem_size_t: SIZE_BYTE, SIZE_HALF, SIZE_WORD.
- req_signed  in  1  load result is sign-extended (1) or zero-extended (0).
- req_addr  in  32  byte address (size_t).
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse when the transaction completes (loads and stores).
- resp_rdata  out  32  extended load data; 0 for stores; held until the next response.
- address  out  32  Avalon word-aligned address ({req_addr[31:2],2'b00}).
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- byteenable  out  4  Avalon byte lanes.
- writedata  out  32  Avalon write data.
- readdata  in  32  Avalon read data, valid exactly 1 cycle after read is accepted.
- waitrequest  in  1  slave stall.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; read=0, write=0, byteenable=0, writedata=0, address=RESET_ADDR, resp_valid=0, resp_rdata=0.
- Reset mid-transaction aborts it: no resp_valid, and read/write drop in the same cycle reset asserts.
- All outputs except req_ready are registered. req_ready = (state==IDLE).
- IDLE: on accept, latch the request, drive address/read/write/byteenable/writedata, go to CMD.
- CMD: read or write is high. address, byteenable and writedata are held stable while waitrequest=1.
  - waitrequest=0 and write: deassert write, go to RESP.
  - waitrequest=0 and read: deassert read, go to RDATA.
- RDATA: sample readdata, extract lane, extend into resp_rdata, go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency with zero waitrequest cycles:
  - Store: accept edge T; write high T+1; resp_valid T+2.
  - Load: read high T+1; resp_valid T+3.
  - Each waitrequest=1 cycle in CMD adds 1 cycle.
- Lanes (lane = req_addr[1:0]):
  - Byte: byteenable = 4'b0001<<lane; writedata = {4{wdata[7:0]}}.
  - Half: byteenable = addr[1] ? 1100 : 0011; writedata = {2{wdata[15:0]}}.
  - Word: byteenable = 1111; writedata = wdata.
- Load extraction:
  - Byte: readdata[8*lane +: 8].
  - Half: readdata[16*addr[1] +: 16].
  - Word: readdata unchanged.
  - Byte and half results are extended to 32 bits per req_signed.
- Misalignment with the macro off: low address bits are ignored. Half ignores addr[0]; word ignores addr[1:0].
- req_valid while busy is ignored; the request is not queued.
- read and write are never high together.

Optional Feature:
- Macro AVALON_MEM_MASTER_ALIGN_CHECK_EN.
- Defined:
  - Extra output resp_error (1 bit, reset 0).
  - A misaligned half (addr[0]=1) or word (addr[1:0]!=0) request issues no bus cycle. IDLE goes straight to RESP, with resp_valid=1, resp_error=1 and resp_rdata=0 at T+1.
  - resp_error=0 on every normal response.
- Undefined: no resp_error port; silent force-align as above.

Decomposition:
- Package codes: size_t (existing); new mem_size_t enum (2 bits); state enum {IDLE, CMD, RDATA, RESP}.
- One sub-module, mem_lane_align: combinational; computes byteenable/writedata from (size, addr[1:0], wdata) and extends read data from (size, signed, addr[1:0], readdata).
- The FSM stays in avalon_mem_master.

Test Plan:
- Store word 0xDEADBEEF to 0xBFC00010, waitrequest=0 -> T+1: write=1, address=BFC00010, byteenable=1111, writedata=DEADBEEF; resp_valid at T+2, resp_rdata=0.
- Store byte 0xA5 to 0xBFC00013 -> byteenable=1000, writedata=A5A5A5A5, address=BFC00010.
- Load byte from 0xBFC00013, slave word 0x80112233 -> signed: resp_rdata=FFFFFF80 at T+3; unsigned: 00000080.
- Load half signed from 0xBFC00012, word 0x80112233, waitrequest=1 for 3 cycles -> read held T+1..T+4 with address stable; resp_rdata=FFFF8011, resp_valid at T+6.
- reset_n low during CMD with waitrequest=1 -> read=0 immediately, no resp_valid; after release req_ready=1 and address=BFC00000.
- Load word from 0xBFC00002:
  - Macro on: no read, resp_valid=1 and resp_error=1 at T+1.
  - Macro off: address=BFC00000, byteenable=1111.
